// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register pair feeding a byte FIFO.
// Define UART_TX_OVERFLOW_FLAG_EN to compile in the sticky overflow flag (STATUS bit3).
module uart_tx_mmio #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Tx
);

  localparam int unsigned PtrW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] StatusAddr  = BASE_ADDR + 32'd4;
  localparam int unsigned BaudTop     = CLK_DIV - 1;
  localparam logic [15:0] BaudMax     = BaudTop[15:0];
  localparam logic [PtrW:0] FullCount = FIFO_DEPTH[PtrW:0];

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [PtrW:0]   count;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic [15:0]     baud;
  logic            full, empty, busy, overflow;
  logic            data_sel, status_sel, push_req, push, pop, baud_wrap;
  logic            unused_wdata;

  assign data_sel   = (Addr == BASE_ADDR);
  assign status_sel = (Addr == StatusAddr);
  assign Hit        = data_sel | status_sel;

  assign full      = (count == FullCount);
  assign empty     = (count == '0);
  assign busy      = (state != StIdle);
  assign pop       = (state == StIdle) && !empty;
  assign push_req  = MemWrite && data_sel;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push      = push_req && (!full || pop);
  assign baud_wrap = (baud == BaudMax);

  assign unused_wdata = ^WriteData[31:8];

  always_comb begin
    ReadData = '0;
    if (status_sel) begin
      ReadData[0]             = full;
      ReadData[1]             = empty;
      ReadData[2]             = busy;
      ReadData[3]             = overflow;
      ReadData[8 +: PtrW + 1] = count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= WriteData[7:0];
  end

`ifdef UART_TX_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)                       overflow <= 1'b0;
    else if (push_req && !push)    overflow <= 1'b1;
    else if (MemWrite && status_sel) overflow <= 1'b0;
  end
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      shreg   <= '0;
      bit_cnt <= '0;
      baud    <= '0;
      Tx      <= 1'b1;
    end else begin
      if (state == StIdle) baud <= '0;
      else                 baud <= baud_wrap ? '0 : baud + 1'b1;
      unique case (state)
        StIdle: begin
          if (!empty) begin
            shreg   <= mem[rd_ptr];
            bit_cnt <= '0;
            state   <= StStart;
            Tx      <= 1'b0;
          end
        end
        StStart: begin
          if (baud_wrap) begin
            state <= StData;
            Tx    <= shreg[0];
          end
        end
        StData: begin
          if (baud_wrap) begin
            if (bit_cnt == 3'd7) begin
              state <= StStop;
              Tx    <= 1'b1;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              Tx      <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        StStop: begin
          if (baud_wrap) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;

  localparam int unsigned ClkDiv  = 4;
  localparam int unsigned Depth   = 8;
  localparam logic [31:0] Base    = 32'h0000_1000;
  localparam logic [31:0] StatusA = 32'h0000_1004;
`ifdef UART_TX_OVERFLOW_FLAG_EN
  localparam logic OvfEn = 1'b1;
`else
  localparam logic OvfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic       mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  uart_tx_mmio #(
    .CLK_DIV   (ClkDiv),
    .FIFO_DEPTH(Depth),
    .BASE_ADDR (Base)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemWrite (mem_write),
    .Addr     (addr),
    .WriteData(wdata),
    .ReadData (rdata),
    .Hit      (hit),
    .Tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serial receiver: samples mid-bit on falling edges; index 0 is the first start-bit sample.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy <= 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy <= 1'b1;
        mon_cnt  <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == 38) begin
        check_eq("stop_bit", {31'd0, tx}, 32'd1);
        rx_q.push_back(mon_byte);
        mon_busy <= 1'b0;
      end else if (mon_cnt >= 6 && (mon_cnt % 4) == 2) begin
        mon_byte <= {tx, mon_byte[7:1]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] v);
    addr = StatusA;
    #1;
    v = rdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 2000; i++) begin
      read_status(s);
      if (s == 32'h2) break;
      tick();
    end
    check_eq(tag, s, 32'h2);
  endtask

  task automatic wait_rx(input string tag, input int n);
    for (int i = 0; i < 1000 && rx_q.size() < n; i++) tick();
    check_eq(tag, rx_q.size(), n);
  endtask

  initial begin
    logic [31:0] s;
    logic [9:0]  frame;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_tx", {31'd0, tx}, 32'd1);
    read_status(s);
    check_eq("reset_status", s, 32'h2);
    check_eq("reset_status_hit", {31'd0, hit}, 32'd1);
    addr = Base;
    #1;
    check_eq("txdata_hit", {31'd0, hit}, 32'd1);
    check_eq("txdata_read", rdata, 32'h0);

    // Single frame of 0xA5: start, LSB-first data, stop
    frame = {1'b1, 8'hA5, 1'b0};
    write(Base, 32'hFFFF_FFA5);
    read_status(s);
    check_eq("store_count", s, 32'h0000_0100);
    check_eq("store_tx_idle", {31'd0, tx}, 32'd1);
    tick();
    for (int c = 0; c < 40; c++) begin
      check_eq($sformatf("frame_c%0d", c), {31'd0, tx}, {31'd0, frame[c / 4]});
      if (c == 0 || c == 39) begin
        read_status(s);
        check_eq($sformatf("frame_busy_c%0d", c), {31'd0, s[2]}, 32'd1);
      end
      tick();
    end
    read_status(s);
    check_eq("frame_done_status", s, 32'h2);
    check_eq("frame_done_tx", {31'd0, tx}, 32'd1);
    wait_rx("single_rx_count", 1);
    if (rx_q.size() > 0) check_eq("single_rx_byte", {24'd0, rx_q[0]}, 32'hA5);
    rx_q.delete();

    // Fill: 9 consecutive writes, first is popped on the second edge
    for (int b = 1; b <= 9; b++) begin
      mem_write = 1'b1;
      addr      = Base;
      wdata     = b;
      tick();
    end
    mem_write = 1'b0;
    read_status(s);
    check_eq("fill_status", s, 32'h0000_0805);
    wait_rx("fill_rx_count", 9);
    wait_idle("fill_idle");
    check_eq("fill_total", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check_eq($sformatf("fill_byte%0d", i), {24'd0, rx_q[i]}, i + 1);
    rx_q.delete();

    // Overflow: 12 writes, last 3 dropped
    for (int b = 0; b < 12; b++) begin
      mem_write = 1'b1;
      addr      = Base;
      wdata     = 32'h10 + b;
      tick();
    end
    mem_write = 1'b0;
    read_status(s);
    check_eq("ovf_status", s, OvfEn ? 32'h0000_080D : 32'h0000_0805);
    write(StatusA, 32'h0);
    read_status(s);
    check_eq("ovf_cleared", s, 32'h0000_0805);
    wait_rx("ovf_rx_count", 9);
    wait_idle("ovf_idle");
    check_eq("ovf_total", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check_eq($sformatf("ovf_byte%0d", i), {24'd0, rx_q[i]}, 32'h10 + i);
    rx_q.delete();

    // Decode: neighbouring and misaligned addresses are ignored
    write(Base + 32'd8, 32'h55);
    write(Base + 32'd1, 32'h66);
    addr = Base + 32'd8;
    #1;
    check_eq("dec8_hit", {31'd0, hit}, 32'd0);
    check_eq("dec8_read", rdata, 32'h0);
    addr = Base + 32'd1;
    #1;
    check_eq("dec1_hit", {31'd0, hit}, 32'd0);
    check_eq("dec1_read", rdata, 32'h0);
    read_status(s);
    check_eq("dec_status", s, 32'h2);
    repeat (3) tick();
    check_eq("dec_tx", {31'd0, tx}, 32'd1);
    read_status(s);
    check_eq("dec_status_later", s, 32'h2);

    // Reset mid-frame with 3 bytes queued
    for (int b = 0; b < 4; b++) begin
      mem_write = 1'b1;
      addr      = Base;
      wdata     = (b == 0) ? 32'h00 : 32'h30 + b;
      tick();
    end
    mem_write = 1'b0;
    repeat (4) tick();
    check_eq("mid_tx_low", {31'd0, tx}, 32'd0);
    read_status(s);
    check_eq("mid_status", s, 32'h0000_0304);
    rst = 1'b1;
    tick();
    check_eq("mid_reset_tx", {31'd0, tx}, 32'd1);
    read_status(s);
    check_eq("mid_reset_status", s, 32'h2);
    rst = 1'b0;
    repeat (50) tick();
    check_eq("post_reset_tx", {31'd0, tx}, 32'd1);
    read_status(s);
    check_eq("post_reset_status", s, 32'h2);
    check_eq("post_reset_rx", rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
